// File: rtl/bsg_axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and small elaboration helpers
// used by the CSR responder and its address decoder.
package bsg_axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axil_resp_e;

  function automatic axil_resp_e resp_of(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

  // Width of a register index; never zero so single-register banks still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_axil_csr_decode.sv
// Maps a byte address onto a CSR index and reports whether it lands in the
// bank at all and whether it lands in the read/write part of it.
module bsg_axil_csr_decode
  import bsg_axil_pkg::*;
#(
  parameter int                      addr_width_p  = 32,
  parameter int                      data_width_p  = 32,
  parameter logic [addr_width_p-1:0] base_addr_p   = addr_width_p'('h1000),
  parameter int                      num_rw_regs_p = 8,
  parameter int                      num_ro_regs_p = 4
) (
  input  logic [addr_width_p-1:0]                                 addr,
  output logic [idx_width(num_rw_regs_p + num_ro_regs_p)-1:0]     idx,
  output logic                                                    hit,
  output logic                                                    is_rw
);

  localparam int num_regs_lp  = num_rw_regs_p + num_ro_regs_p;
  localparam int idx_width_lp = idx_width(num_regs_lp);
  localparam int lg_bytes_lp  = $clog2(data_width_p / 8);

  logic [addr_width_p-1:0] off;
  logic [addr_width_p-1:0] word;

  // Sub-word byte bits fall off in the shift; below-base addresses wrap high
  // and are rejected by the explicit base comparison.
  assign off   = addr - base_addr_p;
  assign word  = off >> lg_bytes_lp;
  assign hit   = (addr >= base_addr_p) && (word < addr_width_p'(num_regs_lp));
  assign idx   = word[idx_width_lp-1:0];
  assign is_rw = hit && (idx < idx_width_lp'(num_rw_regs_p));

endmodule

// File: rtl/bsg_axil_csr_responder.sv
// AXI4-Lite responder exposing a bank of read/write CSRs driven to the design
// followed by read-only status words sampled from it.
module bsg_axil_csr_responder
  import bsg_axil_pkg::*;
#(
  parameter int                      addr_width_p  = 32,
  parameter int                      data_width_p  = 32,
  parameter logic [addr_width_p-1:0] base_addr_p   = addr_width_p'('h1000),
  parameter int                      num_rw_regs_p = 8,
  parameter int                      num_ro_regs_p = 4
) (
  input  logic                                    aclk_i,
  input  logic                                    aresetn_i,

  input  logic [addr_width_p-1:0]                 awaddr_i,
  input  logic [2:0]                              awprot_i,
  input  logic                                    awvalid_i,
  output logic                                    awready_o,

  input  logic [data_width_p-1:0]                 wdata_i,
  input  logic [data_width_p/8-1:0]               wstrb_i,
  input  logic                                    wvalid_i,
  output logic                                    wready_o,

  output logic [1:0]                              bresp_o,
  output logic                                    bvalid_o,
  input  logic                                    bready_i,

  input  logic [addr_width_p-1:0]                 araddr_i,
  input  logic [2:0]                              arprot_i,
  input  logic                                    arvalid_i,
  output logic                                    arready_o,

  output logic [data_width_p-1:0]                 rdata_o,
  output logic [1:0]                              rresp_o,
  output logic                                    rvalid_o,
  input  logic                                    rready_i,

  output logic [num_rw_regs_p*data_width_p-1:0]   csr_o,
  output logic [num_rw_regs_p-1:0]                csr_wr_v_o,
  input  logic [num_ro_regs_p*data_width_p-1:0]   status_i
);

  localparam int strb_width_lp = data_width_p / 8;
  localparam int idx_width_lp  = idx_width(num_rw_regs_p + num_ro_regs_p);

  typedef struct packed {
    logic                    v;
    logic [addr_width_p-1:0] addr;
  } aw_slot_t;

  typedef struct packed {
    logic                     v;
    logic [data_width_p-1:0]  data;
    logic [strb_width_lp-1:0] strb;
  } w_slot_t;

  aw_slot_t                aw_slot;
  w_slot_t                 w_slot;
  logic [data_width_p-1:0] regs [num_rw_regs_p];

  logic [idx_width_lp-1:0] w_idx, r_idx;
  logic                    w_hit, w_is_rw, w_ok;
  logic                    r_hit, r_is_rw;
  logic                    commit;
  logic [data_width_p-1:0] rd_word;

  logic unused_prot;
  assign unused_prot = ^{awprot_i, arprot_i};

  bsg_axil_csr_decode #(
    .addr_width_p (addr_width_p),
    .data_width_p (data_width_p),
    .base_addr_p  (base_addr_p),
    .num_rw_regs_p(num_rw_regs_p),
    .num_ro_regs_p(num_ro_regs_p)
  ) u_wr_decode (
    .addr (aw_slot.addr),
    .idx  (w_idx),
    .hit  (w_hit),
    .is_rw(w_is_rw)
  );

  bsg_axil_csr_decode #(
    .addr_width_p (addr_width_p),
    .data_width_p (data_width_p),
    .base_addr_p  (base_addr_p),
    .num_rw_regs_p(num_rw_regs_p),
    .num_ro_regs_p(num_ro_regs_p)
  ) u_rd_decode (
    .addr (araddr_i),
    .idx  (r_idx),
    .hit  (r_hit),
    .is_rw(r_is_rw)
  );

  assign awready_o = ~aw_slot.v;
  assign wready_o  = ~w_slot.v;
  assign arready_o = ~rvalid_o;
  assign w_ok      = w_hit & w_is_rw;

  // A pending B response blocks the next commit, so back-to-back writes
  // cannot overwrite a response the initiator has not yet accepted.
  assign commit = aw_slot.v & w_slot.v & ~bvalid_o;

  // NOTE: every variable in always_comb is given a default before any
  // conditional assignment; a missed path would otherwise infer a latch.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < num_rw_regs_p; i++) begin
      if (r_is_rw && (r_idx == idx_width_lp'(i))) rd_word = regs[i];
    end
    for (int j = 0; j < num_ro_regs_p; j++) begin
      if (r_hit && !r_is_rw && (r_idx == idx_width_lp'(num_rw_regs_p + j)))
        rd_word = status_i[j*data_width_p +: data_width_p];
    end
  end

  // NOTE: the register bank is built from flops, not a RAM, so it takes the
  // async reset like any other state; software expects zeroed CSRs.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < num_rw_regs_p; i++) regs[i] <= '0;
    end else if (commit && w_ok) begin
      for (int i = 0; i < num_rw_regs_p; i++) begin
        if (w_idx == idx_width_lp'(i)) begin
          for (int b = 0; b < strb_width_lp; b++) begin
            if (w_slot.strb[b]) regs[i][b*8 +: 8] <= w_slot.data[b*8 +: 8];
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so a read in
  // the commit cycle sees the pre-write register value.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      aw_slot    <= '0;
      w_slot     <= '0;
      bvalid_o   <= 1'b0;
      bresp_o    <= '0;
      csr_wr_v_o <= '0;
    end else begin
      if (commit)                        aw_slot   <= '0;
      else if (awvalid_i && awready_o)   aw_slot   <= '{v: 1'b1, addr: awaddr_i};

      if (commit)                        w_slot    <= '0;
      else if (wvalid_i && wready_o)     w_slot    <= '{v: 1'b1, data: wdata_i, strb: wstrb_i};

      if (commit) begin
        bvalid_o <= 1'b1;
        bresp_o  <= resp_of(w_ok);
      end else if (bready_i) begin
        bvalid_o <= 1'b0;
      end

      for (int i = 0; i < num_rw_regs_p; i++)
        csr_wr_v_o[i] <= commit && w_ok && (w_idx == idx_width_lp'(i));
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      rresp_o  <= '0;
    end else if (arvalid_i && arready_o) begin
      rvalid_o <= 1'b1;
      rdata_o  <= rd_word;
      rresp_o  <= resp_of(r_hit);
    end else if (rready_i) begin
      rvalid_o <= 1'b0;
    end
  end

  for (genvar i = 0; i < num_rw_regs_p; i++) begin : g_csr
    assign csr_o[i*data_width_p +: data_width_p] = regs[i];
  end

endmodule

// File: tb/tb_bsg_axil_csr_responder.sv
// Self-checking bench for bsg_axil_csr_responder: directed scenarios plus
// randomized traffic checked against a behavioural register-bank model.
`timescale 1ns/1ps
module tb_bsg_axil_csr_responder;

  localparam int          NRW  = 8;
  localparam int          NRO  = 4;
  localparam logic [31:0] BASE = 32'h1000;

  logic               aclk_i, aresetn_i;
  logic [31:0]        awaddr_i, araddr_i, wdata_i, rdata_o;
  logic [2:0]         awprot_i, arprot_i;
  logic [3:0]         wstrb_i;
  logic               awvalid_i, awready_o, wvalid_i, wready_o;
  logic [1:0]         bresp_o, rresp_o;
  logic               bvalid_o, bready_i, arvalid_i, arready_o, rvalid_o, rready_i;
  logic [NRW*32-1:0]  csr_o;
  logic [NRW-1:0]     csr_wr_v_o;
  logic [NRO*32-1:0]  status_i;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;

  logic [31:0] model_regs   [NRW];
  logic [31:0] status_words [NRO];

  assign status_i = {status_words[3], status_words[2], status_words[1], status_words[0]};

  bsg_axil_csr_responder #(
    .addr_width_p (32),
    .data_width_p (32),
    .base_addr_p  (32'h1000),
    .num_rw_regs_p(NRW),
    .num_ro_regs_p(NRO)
  ) dut (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .awaddr_i  (awaddr_i),
    .awprot_i  (awprot_i),
    .awvalid_i (awvalid_i),
    .awready_o (awready_o),
    .wdata_i   (wdata_i),
    .wstrb_i   (wstrb_i),
    .wvalid_i  (wvalid_i),
    .wready_o  (wready_o),
    .bresp_o   (bresp_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready_i),
    .araddr_i  (araddr_i),
    .arprot_i  (arprot_i),
    .arvalid_i (arvalid_i),
    .arready_o (arready_o),
    .rdata_o   (rdata_o),
    .rresp_o   (rresp_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i),
    .csr_o     (csr_o),
    .csr_wr_v_o(csr_wr_v_o),
    .status_i  (status_i)
  );

  initial aclk_i = 1'b0;
  always #5 aclk_i = ~aclk_i;

  always @(negedge aclk_i) pulse_count += $countones(csr_wr_v_o);

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    for (int i = 0; i < NRW; i++) model_regs[i] = '0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int idx;
    resp = 2'b10;
    if (addr >= BASE && ((addr - BASE) / 4) < NRW) begin
      idx = int'((addr - BASE) / 4);
      for (int b = 0; b < 4; b++) if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
      resp = 2'b00;
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int idx;
    data = '0;
    resp = 2'b10;
    if (addr >= BASE && ((addr - BASE) / 4) < NRW + NRO) begin
      idx  = int'((addr - BASE) / 4);
      resp = 2'b00;
      data = (idx < NRW) ? model_regs[idx] : status_words[idx - NRW];
    end
  endtask

  function automatic logic [NRW*32-1:0] model_csr();
    logic [NRW*32-1:0] v;
    for (int i = 0; i < NRW; i++) v[i*32 +: 32] = model_regs[i];
    return v;
  endfunction

  // ---------------- bus drivers ----------------
  task automatic tick();
    @(posedge aclk_i);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, output logic [1:0] resp);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    awaddr_i = addr;
    wdata_i  = data;
    wstrb_i  = strb;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid_i = !aw_done && (cyc >= aw_dly);
      wvalid_i  = !w_done && (cyc >= w_dly);
      aw_hs = awvalid_i && awready_o;
      w_hs  = wvalid_i && wready_o;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    awvalid_i = 0;
    wvalid_i  = 0;
    if (!(aw_done && w_done)) begin
      checks++; errors++;
      $display("FAIL write_accept_timeout: addr %h aw_done %0b w_done %0b, expected both accepted", addr, aw_done, w_done);
    end
    bready_i = 1;
    cyc = 0;
    while (!bvalid_o && cyc < 50) begin tick(); cyc++; end
    resp = bresp_o;
    if (!bvalid_o) begin
      checks++; errors++;
      $display("FAIL write_resp_timeout: addr %h bvalid %0b, expected 1", addr, bvalid_o);
      resp = 2'bxx;
    end
    tick();
    bready_i = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc = 0;
    bit done = 0;
    araddr_i  = addr;
    arvalid_i = 1;
    while (!done && cyc < 50) begin done = arready_o; tick(); cyc++; end
    arvalid_i = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_accept_timeout: addr %h arready never seen, expected 1", addr);
    end
    rready_i = 1;
    cyc = 0;
    while (!rvalid_o && cyc < 50) begin tick(); cyc++; end
    data = rdata_o;
    resp = rresp_o;
    if (!rvalid_o) begin
      checks++; errors++;
      $display("FAIL read_resp_timeout: addr %h rvalid %0b, expected 1", addr, rvalid_o);
      resp = 2'bxx;
    end
    tick();
    rready_i = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn_i = 0;
    repeat (3) tick();
    aresetn_i = 1;
    model_reset();
    tick();
    checks++;
    if ({awready_o, wready_o, arready_o} !== 3'b111) begin
      errors++; $display("FAIL reset_readies: got %b expected 111", {awready_o, wready_o, arready_o});
    end
    checks++;
    if ({bvalid_o, rvalid_o} !== 2'b00) begin
      errors++; $display("FAIL reset_valids: got %b expected 00", {bvalid_o, rvalid_o});
    end
    checks++;
    if (csr_o !== model_csr() || csr_wr_v_o !== '0) begin
      errors++; $display("FAIL reset_csr: csr %h pulse %h expected all zero", csr_o, csr_wr_v_o);
    end
    checks++;
    if ({bresp_o, rresp_o} !== 4'b0000 || rdata_o !== 32'h0) begin
      errors++; $display("FAIL reset_resp: bresp %b rresp %b rdata %h expected 0", bresp_o, rresp_o, rdata_o);
    end
  endtask

  task automatic test_same_cycle_write();
    logic [1:0] mresp;
    bready_i  = 0;
    awaddr_i  = 32'h1004;
    wdata_i   = 32'hDEADBEEF;
    wstrb_i   = 4'hF;
    awvalid_i = 1;
    wvalid_i  = 1;
    tick();
    awvalid_i = 0;
    wvalid_i  = 0;
    model_write(32'h1004, 32'hDEADBEEF, 4'hF, mresp);
    checks++;
    if (bvalid_o !== 1'b0) begin
      errors++; $display("FAIL same_cycle_early_b: bvalid %0b expected 0 one cycle after handshake", bvalid_o);
    end
    tick();
    checks++;
    if (bvalid_o !== 1'b1 || bresp_o !== mresp) begin
      errors++; $display("FAIL same_cycle_b: bvalid %0b bresp %b expected 1 %b", bvalid_o, bresp_o, mresp);
    end
    checks++;
    if (csr_o !== model_csr()) begin
      errors++; $display("FAIL same_cycle_csr: got %h expected %h", csr_o, model_csr());
    end
    checks++;
    if (csr_wr_v_o !== 8'h02) begin
      errors++; $display("FAIL same_cycle_pulse: got %h expected 02", csr_wr_v_o);
    end
    tick();
    checks++;
    if (csr_wr_v_o !== 8'h00 || bvalid_o !== 1'b1) begin
      errors++; $display("FAIL same_cycle_pulse_end: pulse %h bvalid %0b expected 00 1", csr_wr_v_o, bvalid_o);
    end
    bready_i = 1;
    tick();
    bready_i = 0;
    checks++;
    if (bvalid_o !== 1'b0) begin
      errors++; $display("FAIL same_cycle_b_clear: bvalid %0b expected 0", bvalid_o);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp, mresp;
    int p0 = pulse_count;
    do_write(32'h1004, 32'h12345678, 4'h3, 3, 0, resp);
    model_write(32'h1004, 32'h12345678, 4'h3, mresp);
    checks++;
    if (resp !== mresp) begin
      errors++; $display("FAIL w_first_resp: got %b expected %b", resp, mresp);
    end
    checks++;
    if (csr_o[63:32] !== 32'hDEAD5678 || csr_o !== model_csr()) begin
      errors++; $display("FAIL w_first_csr: reg1 %h expected DEAD5678", csr_o[63:32]);
    end
    checks++;
    if (pulse_count !== p0 + 1) begin
      errors++; $display("FAIL w_first_pulse: pulses %0d expected %0d", pulse_count - p0, 1);
    end
  endtask

  task automatic test_error_writes();
    logic [31:0] addrs [6];
    logic [1:0]  resp, mresp;
    int p0;
    addrs = '{32'h1020, 32'h2000, 32'h0FFC, 32'h102C, 32'h1030, 32'h101C};
    for (int k = 0; k < 6; k++) begin
      logic [31:0] d;
      d  = $urandom;
      p0 = pulse_count;
      do_write(addrs[k], d, 4'hF, 0, 0, resp);
      model_write(addrs[k], d, 4'hF, mresp);
      checks++;
      if (resp !== mresp) begin
        errors++; $display("FAIL err_write_resp: addr %h got %b expected %b", addrs[k], resp, mresp);
      end
      checks++;
      if (csr_o !== model_csr()) begin
        errors++; $display("FAIL err_write_csr: addr %h got %h expected %h", addrs[k], csr_o, model_csr());
      end
      checks++;
      if (pulse_count - p0 !== ((mresp == 2'b00) ? 1 : 0)) begin
        errors++; $display("FAIL err_write_pulse: addr %h pulses %0d expected %0d", addrs[k], pulse_count - p0, (mresp == 2'b00) ? 1 : 0);
      end
    end
  endtask

  task automatic test_ro_read();
    status_words[1] = 32'hCAFEF00D;
    rready_i  = 0;
    araddr_i  = 32'h1024;
    arvalid_i = 1;
    checks++;
    if (arready_o !== 1'b1) begin
      errors++; $display("FAIL ro_arready_idle: got %0b expected 1", arready_o);
    end
    tick();
    arvalid_i = 0;
    status_words[1] = 32'h0BADF00D;
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'hCAFEF00D || rresp_o !== 2'b00 || arready_o !== 1'b0) begin
      errors++; $display("FAIL ro_first: rvalid %0b rdata %h rresp %b arready %0b expected 1 cafef00d 00 0", rvalid_o, rdata_o, rresp_o, arready_o);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (rvalid_o !== 1'b1 || rdata_o !== 32'hCAFEF00D || rresp_o !== 2'b00 || arready_o !== 1'b0) begin
        errors++; $display("FAIL ro_hold: cycle %0d rvalid %0b rdata %h arready %0b expected 1 cafef00d 0", c, rvalid_o, rdata_o, arready_o);
      end
    end
    rready_i = 1;
    tick();
    rready_i = 0;
    checks++;
    if (rvalid_o !== 1'b0 || arready_o !== 1'b1) begin
      errors++; $display("FAIL ro_release: rvalid %0b arready %0b expected 0 1", rvalid_o, arready_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    logic [1:0]  mresp;
    d1 = $urandom;
    d2 = ~d1;
    bready_i  = 0;
    awaddr_i  = 32'h1008;
    wdata_i   = d1;
    wstrb_i   = 4'hF;
    awvalid_i = 1;
    wvalid_i  = 1;
    tick();
    awvalid_i = 0;
    wvalid_i  = 0;
    tick();
    model_write(32'h1008, d1, 4'hF, mresp);
    checks++;
    if (bvalid_o !== 1'b1 || bresp_o !== mresp || csr_o[95:64] !== d1) begin
      errors++; $display("FAIL b2b_first: bvalid %0b bresp %b reg2 %h expected 1 %b %h", bvalid_o, bresp_o, csr_o[95:64], mresp, d1);
    end
    wdata_i   = d2;
    awvalid_i = 1;
    wvalid_i  = 1;
    checks++;
    if (awready_o !== 1'b1 || wready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_slots_free: awready %0b wready %0b expected 1 1", awready_o, wready_o);
    end
    tick();
    awvalid_i = 0;
    wvalid_i  = 0;
    checks++;
    if (awready_o !== 1'b0 || wready_o !== 1'b0) begin
      errors++; $display("FAIL b2b_slots_full: awready %0b wready %0b expected 0 0", awready_o, wready_o);
    end
    repeat (3) tick();
    checks++;
    if (bvalid_o !== 1'b1 || csr_o !== model_csr()) begin
      errors++; $display("FAIL b2b_held: bvalid %0b reg2 %h expected 1 %h", bvalid_o, csr_o[95:64], d1);
    end
    bready_i = 1;
    tick();
    bready_i = 0;
    checks++;
    if (bvalid_o !== 1'b0 || csr_o !== model_csr()) begin
      errors++; $display("FAIL b2b_gap: bvalid %0b reg2 %h expected 0 %h", bvalid_o, csr_o[95:64], d1);
    end
    tick();
    model_write(32'h1008, d2, 4'hF, mresp);
    checks++;
    if (bvalid_o !== 1'b1 || bresp_o !== mresp || csr_o !== model_csr() || csr_wr_v_o !== 8'h04) begin
      errors++; $display("FAIL b2b_second: bvalid %0b bresp %b reg2 %h pulse %h expected 1 %b %h 04", bvalid_o, bresp_o, csr_o[95:64], csr_wr_v_o, mresp, d2);
    end
    bready_i = 1;
    tick();
    bready_i = 0;
    checks++;
    if (bvalid_o !== 1'b0 || awready_o !== 1'b1) begin
      errors++; $display("FAIL b2b_done: bvalid %0b awready %0b expected 0 1", bvalid_o, awready_o);
    end
  endtask

  task automatic test_read_write_collision();
    logic [31:0] old_v, new_v, d_exp;
    logic [1:0]  mresp, r_exp;
    model_read(32'h100C, old_v, r_exp);
    new_v     = $urandom;
    bready_i  = 0;
    rready_i  = 0;
    awaddr_i  = 32'h100C;
    wdata_i   = new_v;
    wstrb_i   = 4'hF;
    awvalid_i = 1;
    wvalid_i  = 1;
    tick();
    awvalid_i = 0;
    wvalid_i  = 0;
    araddr_i  = 32'h100C;
    arvalid_i = 1;
    tick();
    arvalid_i = 0;
    model_write(32'h100C, new_v, 4'hF, mresp);
    model_read(32'h100C, d_exp, mresp);
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== old_v || rresp_o !== r_exp) begin
      errors++; $display("FAIL collide_read_old: rvalid %0b rdata %h expected 1 %h", rvalid_o, rdata_o, old_v);
    end
    checks++;
    if (csr_o[127:96] !== d_exp || bvalid_o !== 1'b1) begin
      errors++; $display("FAIL collide_write: reg3 %h bvalid %0b expected %h 1", csr_o[127:96], bvalid_o, d_exp);
    end
    bready_i = 1;
    rready_i = 1;
    tick();
    bready_i = 0;
    rready_i = 0;
  endtask

  task automatic test_random();
    logic [31:0] addr, data, d_exp, d_got;
    logic [3:0]  strb;
    logic [1:0]  resp, mresp;
    for (int i = 0; i < NRO; i++) status_words[i] = $urandom;
    for (int n = 0; n < 60; n++) begin
      addr = 32'h0FF0 + 32'($urandom_range(0, 32'h50));
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        strb = 4'($urandom);
        do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp);
        model_write(addr, data, strb, mresp);
        checks++;
        if (resp !== mresp || csr_o !== model_csr()) begin
          errors++; $display("FAIL rand_write: addr %h resp %b csr %h expected %b %h", addr, resp, csr_o, mresp, model_csr());
        end
      end else begin
        model_read(addr, d_exp, mresp);
        do_read(addr, d_got, resp);
        checks++;
        if (resp !== mresp || d_got !== d_exp) begin
          errors++; $display("FAIL rand_read: addr %h rdata %h rresp %b expected %h %b", addr, d_got, resp, d_exp, mresp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  mresp;
    bready_i  = 0;
    rready_i  = 0;
    awaddr_i  = 32'h1000;
    wdata_i   = 32'h55AA55AA;
    wstrb_i   = 4'hF;
    awvalid_i = 1;
    wvalid_i  = 1;
    tick();
    awvalid_i = 0;
    wvalid_i  = 0;
    araddr_i  = 32'h1000;
    arvalid_i = 1;
    tick();
    arvalid_i = 0;
    awaddr_i  = 32'h1010;
    awvalid_i = 1;
    tick();
    awvalid_i = 0;
    checks++;
    if (bvalid_o !== 1'b1 || rvalid_o !== 1'b1) begin
      errors++; $display("FAIL mid_reset_setup: bvalid %0b rvalid %0b expected 1 1", bvalid_o, rvalid_o);
    end
    aresetn_i = 0;
    model_reset();
    #1;
    checks++;
    if (bvalid_o !== 1'b0 || rvalid_o !== 1'b0 || csr_o !== model_csr() || csr_wr_v_o !== '0) begin
      errors++; $display("FAIL mid_reset_drop: bvalid %0b rvalid %0b csr %h expected 0 0 0", bvalid_o, rvalid_o, csr_o);
    end
    tick();
    tick();
    aresetn_i = 1;
    tick();
    checks++;
    if ({awready_o, wready_o, arready_o} !== 3'b111) begin
      errors++; $display("FAIL mid_reset_readies: got %b expected 111", {awready_o, wready_o, arready_o});
    end
    d         = $urandom;
    wdata_i   = d;
    wvalid_i  = 1;
    tick();
    wvalid_i  = 0;
    repeat (3) tick();
    checks++;
    if (bvalid_o !== 1'b0 || csr_o !== model_csr()) begin
      errors++; $display("FAIL mid_reset_no_partial: bvalid %0b csr %h expected 0 %h", bvalid_o, csr_o, model_csr());
    end
    awaddr_i  = 32'h1010;
    awvalid_i = 1;
    tick();
    awvalid_i = 0;
    tick();
    model_write(32'h1010, d, 4'hF, mresp);
    checks++;
    if (bvalid_o !== 1'b1 || bresp_o !== mresp || csr_o !== model_csr()) begin
      errors++; $display("FAIL mid_reset_complete: bvalid %0b bresp %b csr %h expected 1 %b %h", bvalid_o, bresp_o, csr_o, mresp, model_csr());
    end
    bready_i = 1;
    tick();
    bready_i = 0;
  endtask

  initial begin
    aresetn_i = 0;
    awaddr_i  = '0; awprot_i = '0; awvalid_i = 0;
    wdata_i   = '0; wstrb_i  = '0; wvalid_i  = 0;
    bready_i  = 0;
    araddr_i  = '0; arprot_i = '0; arvalid_i = 0;
    rready_i  = 0;
    for (int i = 0; i < NRO; i++) status_words[i] = 32'h0;
    model_reset();

    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_error_writes();
    test_ro_read();
    test_back_to_back();
    test_read_write_collision();
    test_random();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
